// File: rtl/w25q_read_arbiter.sv
// w25q_read_arbiter
// Round-robin arbiter that shares one spi_w25q_read_32b flash reader between
// NUM_REQ requesters. It holds off all grants for STARTUP_CYCLES after reset
// to cover the W25Q tRES1 wake-up time. It then runs one read at a time through
// the reader's start/busy handshake and returns each word to its requester.
//
// Optional build macro: W25Q_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts any ISSUE/WAIT phase that lasts
//   TIMEOUT_CYCLES cycles. The abort pulses err and the ack of the granted
//   requester, and leaves rd_data unchanged.
//   When undefined, err is tied low and the arbiter waits on the reader
//   indefinitely.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-high
//   req         per-requester read request level, held until its ack
//   addr        flattened 24-bit addresses, slice i belongs to requester i
//   ack         one-hot single-cycle pulse, rd_data valid for that requester
//   rd_data     last word read, held until the next ack
//   ready       high once the startup delay has elapsed
//   err         single-cycle pulse on watchdog abort
//   rd_start    reader start
//   rd_addr     reader mem_addr
//   rd_busy     reader busy
//   rd_mem_data reader mem_data
//
// state   | meaning
// STARTUP | waiting out flash wake-up, requests ignored
// IDLE    | arbitrating, reader must be idle before a grant
// ISSUE   | rd_start held high until the reader reports busy
// WAIT    | reader busy, word captured on the first busy low
module w25q_read_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int STARTUP_CYCLES = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [24*NUM_REQ-1:0]   addr,
  output logic [NUM_REQ-1:0]      ack,
  output logic [31:0]             rd_data,
  output logic                    ready,
  output logic                    err,
  output logic                    rd_start,
  output logic [23:0]             rd_addr,
  input  logic                    rd_busy,
  input  logic [31:0]             rd_mem_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES + 1) : 1;

  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_ISSUE   = 2'd2;
  localparam logic [1:0] ST_WAIT    = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] su_cnt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] sel_idx;
  logic          sel_valid;
  logic          grant_go;
  logic          wd_abort;

  // First set request scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin
    int j;
    j         = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!sel_valid && req[j]) begin
        sel_valid = 1'b1;
        sel_idx   = PW'(j);
      end
    end
  end

  // A busy reader in IDLE was left running by a reset, so hold off the grant.
  assign grant_go = (state == ST_IDLE) && sel_valid && !rd_busy;
  assign next_ptr = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

`ifdef W25Q_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;

  // A normal handshake edge in the same cycle takes priority over the abort.
  always_comb begin
    wd_abort = 1'b0;
    if (state == ST_ISSUE)
      wd_abort = !rd_busy && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
    else if (state == ST_WAIT)
      wd_abort = rd_busy && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_cnt <= '0;
    else if (grant_go || (state == ST_ISSUE && rd_busy))
      wd_cnt <= '0;
    else if (state == ST_ISSUE || state == ST_WAIT)
      wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else
      err <= wd_abort;
  end
`else
  assign wd_abort = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_STARTUP;
      su_cnt   <= SW'(STARTUP_CYCLES);
      rr_ptr   <= '0;
      grant    <= '0;
      ack      <= '0;
      rd_data  <= '0;
      ready    <= 1'b0;
      rd_start <= 1'b0;
      rd_addr  <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_STARTUP: begin
          // ready rises on the edge where the count reaches zero.
          if (su_cnt <= SW'(1)) begin
            su_cnt <= '0;
            ready  <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            su_cnt <= su_cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (grant_go) begin
            grant    <= sel_idx;
            rd_addr  <= addr[24*sel_idx +: 24];
            rd_start <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (rd_busy) begin
            rd_start <= 1'b0;
            state    <= ST_WAIT;
          end else if (wd_abort) begin
            rd_start   <= 1'b0;
            ack[grant] <= 1'b1;
            rr_ptr     <= next_ptr;
            state      <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!rd_busy) begin
            rd_data    <= rd_mem_data;
            ack[grant] <= 1'b1;
            rr_ptr     <= next_ptr;
            state      <= ST_IDLE;
          end else if (wd_abort) begin
            ack[grant] <= 1'b1;
            rr_ptr     <= next_ptr;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_w25q_read_arbiter.sv
// Directed testbench for w25q_read_arbiter: NUM_REQ=4, STARTUP_CYCLES=8,
// TIMEOUT_CYCLES=16. A behavioural reader model raises busy on start and
// returns a word derived from the address.
module tb_w25q_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [95:0] addr;
  logic [3:0]  ack;
  logic [31:0] rd_data;
  logic        ready;
  logic        err;
  logic        rd_start;
  logic [23:0] rd_addr;
  logic        rd_busy     = 1'b0;
  logic [31:0] rd_mem_data = 32'h0;

  int n_chk = 0;
  int n_err = 0;

  logic model_en;
  int   busy_len;
  int   bcnt = 0;

  localparam logic [23:0] A0 = 24'h000100;
  localparam logic [23:0] A1 = 24'h001200;
  localparam logic [23:0] A2 = 24'h010000;
  localparam logic [23:0] A3 = 24'h3FF000;

  w25q_read_arbiter #(
    .NUM_REQ(4), .STARTUP_CYCLES(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .ack(ack),
    .rd_data(rd_data), .ready(ready), .err(err), .rd_start(rd_start),
    .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_mem_data(rd_mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    if (a == 24'h010000) return 32'h464c457f;
    return {8'hC3, a};
  endfunction

  // Reader model acts on the falling edge so the DUT sees stable inputs.
  always @(negedge clk) begin
    if (model_en) begin
      if (rd_busy) begin
        bcnt = bcnt - 1;
        if (bcnt <= 0) rd_busy = 1'b0;
      end else if (rd_start) begin
        rd_busy     = 1'b1;
        bcnt        = busy_len;
        rd_mem_data = mem_word(rd_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns a=0 if no ack arrives within the budget; requester drops req on ack.
  task automatic wait_ack(output logic [3:0] a, output logic [31:0] d,
                          output logic [23:0] ad, input int budget);
    a  = '0;
    d  = '0;
    ad = '0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (ack != 4'b0) begin
        a   = ack;
        d   = rd_data;
        ad  = rd_addr;
        req = req & ~ack;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [3:0]  a;
    logic [31:0] d;
    logic [23:0] ad;
    int          bad;
    logic [23:0] exp_addr [4];
    logic [31:0] exp_data [4];
    exp_addr = '{A0, A1, A2, A3};
    exp_data = '{32'hC3000100, 32'hC3001200, 32'h464c457f, 32'hC33FF000};

    rst      = 1'b1;
    req      = 4'b0;
    addr     = {A3, A2, A1, A0};
    model_en = 1'b1;
    busy_len = 3;

    // 1: reset values and startup delay with a request already pending.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_start", rd_start, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_err", err, 0);
    req = 4'b0001;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("su_ready_%0d", k), ready, (k == 8));
      chk($sformatf("su_start_%0d", k), rd_start, 0);
    end
    @(posedge clk); #1;
    chk("t1_start", rd_start, 1);
    chk("t1_addr", rd_addr, A0);
    wait_ack(a, d, ad, 100);
    chk("t1_ack", a, 4'b0001);
    chk("t1_data", d, 32'hC3000100);

    // 2: single read of requester 2, long busy.
    busy_len = 40;
    req = 4'b0100;
    @(posedge clk); #1;
    chk("t2_start", rd_start, 1);
    chk("t2_addr", rd_addr, A2);
    @(posedge clk); #1;
    chk("t2_start_drop", rd_start, 0);
    chk("t2_busy", rd_busy, 1);
    wait_ack(a, d, ad, 100);
    chk("t2_ack", a, 4'b0100);
    chk("t2_data", d, 32'h464c457f);
    @(posedge clk); #1;
    chk("t2_ack_len", ack, 4'b0000);
    chk("t2_err", err, 0);

    // 4: round-robin wrap, pointer is at 3 after serving 2.
    busy_len = 4;
    req = 4'b1001;
    wait_ack(a, d, ad, 100);
    chk("t4_ack_a", a, 4'b1000);
    chk("t4_addr_a", ad, A3);
    chk("t4_data_a", d, 32'hC33FF000);
    wait_ack(a, d, ad, 100);
    chk("t4_ack_b", a, 4'b0001);
    chk("t4_addr_b", ad, A0);
    chk("t4_data_b", d, 32'hC3000100);

    // 5: reset while the reader is busy in WAIT.
    busy_len = 30;
    req = 4'b1000;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (rd_busy && !rd_start) break;
    end
    chk("t5_in_wait", rd_busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_start", rd_start, 0);
    chk("t5_rst_ready", ready, 0);
    chk("t5_rst_ack", ack, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (rd_start || ack != 4'b0) bad++;
      if (k == 7) chk("t5_ready_7", ready, 0);
    end
    chk("t5_ready_8", ready, 1);
    chk("t5_busy_still", rd_busy, 1);
    for (int i = 0; i < 60; i++) begin
      if (!rd_busy) break;
      @(posedge clk); #1;
      if (rd_busy && (rd_start || ack != 4'b0)) bad++;
    end
    chk("t5_hold", bad, 0);
    wait_ack(a, d, ad, 100);
    chk("t5_ack", a, 4'b1000);
    chk("t5_data", d, 32'hC33FF000);

    // 3: full contention, pointer back at 0 after reset and serving 3.
    busy_len = 2;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(a, d, ad, 100);
      chk($sformatf("t3_ack_%0d", i), a, 4'b0001 << i);
      chk($sformatf("t3_addr_%0d", i), ad, exp_addr[i]);
      chk($sformatf("t3_data_%0d", i), d, exp_data[i]);
    end
    chk("t3_err", err, 0);

`ifdef W25Q_ARB_TIMEOUT_EN
    // 6: reader never responds, watchdog aborts requester 2 then 3 is served.
    model_en = 1'b0;
    req = 4'b1100;
    @(posedge clk); #1;
    chk("t6_start", rd_start, 1);
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (err || ack != 4'b0 || !rd_start) bad++;
    end
    chk("t6_quiet", bad, 0);
    @(posedge clk); #1;
    chk("t6_err", err, 1);
    chk("t6_ack", ack, 4'b0100);
    chk("t6_data", rd_data, 32'hC33FF000);
    chk("t6_start_drop", rd_start, 0);
    req = 4'b1000;
    model_en = 1'b1;
    wait_ack(a, d, ad, 100);
    chk("t6_next_ack", a, 4'b1000);
    chk("t6_next_addr", ad, A3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/w25q_read_arbiter.md
Name: w25q_read_arbiter

Overview:
Round-robin arbiter that shares one spi_w25q_read_32b flash reader between NUM_REQ independent requesters. It enforces a post-configuration startup delay, which covers W25Q tRES1 wake-up, before the first read. It sequences the reader's start/busy handshake and returns each 32-bit word to the requester that asked for it. It sits between the reader instance and the user logic in the iCE40 top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
STARTUP_CYCLES, 48, clk cycles held in STARTUP after reset before the first grant (≥3 us at 16 MHz)
TIMEOUT_CYCLES, 1024, watchdog limit per ISSUE/WAIT phase (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  NUM_REQ  per-requester read request level; held high until matching ack
addr  in  24*NUM_REQ  flattened addresses; requester i uses addr[24*i+23:24*i], stable while req[i] high
ack  out  NUM_REQ  one-hot, one-cycle pulse: rd_data valid for that requester
rd_data  out  32  last word read; held until next ack
ready  out  1  high once STARTUP has finished
err  out  1  one-cycle pulse on watchdog abort (constant 0 without feature)
rd_start  out  1  to reader start
rd_addr  out  24  to reader mem_addr
rd_busy  in  1  from reader busy
rd_mem_data  in  32  from reader mem_data

Behaviour:
- Reset values, asynchronous: state=STARTUP; startup counter=STARTUP_CYCLES; rr_ptr=0; ack=0; rd_data=0; ready=0; err=0; rd_start=0; rd_addr=0.
- STARTUP: decrement counter each cycle. At 0, set ready=1 and go to IDLE. req is ignored. ready stays 1 until the next rst.
- IDLE: if any req bit is high, pick the first set index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. Register grant index g. Register rd_addr from addr slice g. Set rd_start=1. Go to ISSUE. Otherwise stay.
- ISSUE: hold rd_start=1 until rd_busy=1 is sampled. Then set rd_start=0 and go to WAIT.
- WAIT: on the first sample of rd_busy=0:
  - rd_data <= rd_mem_data
  - ack[g] <= 1 for exactly one cycle
  - rr_ptr <= (g+1) mod NUM_REQ
  - go to IDLE
- Ack timing: the ack pulse and the new rd_data appear in the same cycle. Earliest re-grant is the cycle after ack. The requester must drop req[g] in the ack cycle, otherwise it is re-arbitrated as a new request.
- Fairness: with all req high, grants rotate 0,1,2,…; no requester waits more than NUM_REQ-1 transactions.
- Requests are never cancelled by the arbiter:
  - req[g] dropping during ISSUE/WAIT does not abort the transaction; ack[g] still pulses.
  - req dropping in IDLE before selection is simply not granted.
- Only one transaction is outstanding at a time. rd_addr is constant from IDLE exit until ack.
- rd_busy already high in IDLE (reader not idle): no grant until it is low. A request pending in IDLE issues only when rd_busy=0.
- rst mid-transaction returns to STARTUP with rd_start=0. The reader is not reset; the full STARTUP delay re-elapses before any new grant, which lets the reader finish. No ack is issued for the aborted read.
- NUM_REQ=1 degenerates to pass-through sequencing; rr_ptr stays 0.

Optional Feature:
W25Q_ARB_TIMEOUT_EN
- Defined: a watchdog counter is cleared on entry to ISSUE and on entry to WAIT, and increments each cycle in those states. When it reaches TIMEOUT_CYCLES:
  - rd_start <= 0, err pulses for 1 cycle, ack[g] pulses with rd_data unchanged
  - rr_ptr advances as normal, state goes to IDLE
- Undefined: no watchdog logic; err is tied 0; ISSUE/WAIT wait indefinitely.

Test Plan:
1. Reset then idle, STARTUP_CYCLES=8 → ready rises exactly 8 cycles after rst release; req[0] held high before that produces no rd_start until then.
2. Single read: req[2]=1, addr2=24'h010000; reader model busy for 40 cycles returning 32'h464c457f → rd_start high until busy seen, then ack=4'b0100 for one cycle with rd_data=32'h464c457f.
3. Contention: req=4'b1111 held, each requester drops req on its ack → acks in order 0001,0010,0100,1000; rd_addr matches each slice in turn.
4. Round-robin wrap: rr_ptr=3 after serving 2, req=4'b1001 → requester 3 granted first, then 0.
5. Reset mid-WAIT (busy high) → rd_start=0 immediately, no ack, ready=0; re-grant only after 8 cycles and rd_busy=0.
6. With W25Q_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, reader never raises busy → err and ack pulse at cycle 16 of ISSUE, rd_data unchanged, next requester served.
